// File: rtl/bert_pkg.sv
// rtl/bert_pkg.sv - shared state encoding and width constants for the BERT slip detector
package bert_pkg;

    localparam int SLIP_RANGE_DEFAULT = 2;
    localparam int SLIP_RANGE_MAX     = 7;
    localparam int OFFSET_WIDTH       = 4;
    localparam int PHASE_WIDTH        = 4;
    localparam int SLIP_COUNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_ADVANCE = 3'd1,
        ST_RETARD  = 3'd2,
        ST_RECOVER = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

    // Every state other than SYNC belongs to a correction sequence
    function automatic logic in_correction(input state_t s);
        return s != ST_SYNC;
    endfunction

endpackage

// File: rtl/bert_run_counter.sv
// rtl/bert_run_counter.sv - saturating run-length counter for one slip candidate
module bert_run_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 mismatch,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (enable) begin
            if (clear || mismatch) begin
                count <= '0;
            end else if (count < limit) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bert_slip_detect_n.sv
// rtl/bert_slip_detect_n.sv - BERT bit-slip detector steering the local LFSR back into alignment
module bert_slip_detect_n
    import bert_pkg::*;
#(
    parameter int SLIP_RANGE   = SLIP_RANGE_DEFAULT,
    parameter int CNT_WIDTH    = 8,
    parameter int RECOVER_BITS = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [CNT_WIDTH-1:0]        limit,
    input  logic [CNT_WIDTH-1:0]        threshold,
    input  logic                        enable,
    input  logic                        reload,
    input  logic                        data,
    input  logic                        code,
    output logic                        lfsr_enable,
    output logic                        blackout,
    output logic                        slip_event,
    output logic [OFFSET_WIDTH-1:0]     slip_offset,
    output logic [SLIP_COUNT_WIDTH-1:0] slip_count
);

    localparam int NCAND = 2 * SLIP_RANGE + 1;

    logic [SLIP_RANGE-1:0]       data_sr;
    logic [SLIP_RANGE:0]         data_win;
    logic [NCAND-2:0]            code_sr;
    logic [NCAND-1:0]            code_win;
    logic [NCAND-1:0]            mismatch;
    logic [CNT_WIDTH-1:0]        run_count [NCAND];
    logic [CNT_WIDTH-1:0]        sync_count;
    logic                        clear_count;
    logic                        counter_clear;

    state_t                      state;
    state_t                      next_state;
    logic [PHASE_WIDTH-1:0]      phase_left;
    logic                        extra_step;
    logic                        slip_request;
    logic [OFFSET_WIDTH-1:0]     sel_offset;
    logic [PHASE_WIDTH-1:0]      sel_steps;

    // Top bit of each window is the sample arriving now; bit 0 is the oldest
    assign data_win = {data, data_sr};
    assign code_win = {code, code_sr};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_sr <= '0;
            code_sr <= '0;
        end else if (enable) begin
            data_sr <= data_win[SLIP_RANGE:1];
            code_sr <= code_win[NCAND-1:1];
        end
    end

    assign clear_count   = (state == ST_CLEAR);
    assign counter_clear = clear_count || reload;
    assign sync_count    = run_count[SLIP_RANGE];

    // Candidate index i = k + SLIP_RANGE lines up with the code tap SLIP_RANGE-k bits old
    for (genvar i = 0; i < NCAND; i++) begin : g_cand
        assign mismatch[i] = data_win[0] ^ code_win[i];

        bert_run_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_run (
            .clock    (clock),
            .reset    (reset),
            .enable   (enable),
            .clear    (counter_clear),
            .mismatch (mismatch[i]),
            .limit    (limit),
            .count    (run_count[i])
        );
    end

    // Smallest slip wins; early beats late at equal magnitude
    always_comb begin
        logic found;
        found      = 1'b0;
        sel_offset = '0;
        sel_steps  = '0;
        for (int m = 1; m <= SLIP_RANGE; m++) begin
            if (!found && (run_count[SLIP_RANGE + m] > threshold)) begin
                found      = 1'b1;
                sel_offset = OFFSET_WIDTH'(m);
                sel_steps  = PHASE_WIDTH'(m);
            end
            if (!found && (run_count[SLIP_RANGE - m] > threshold)) begin
                found      = 1'b1;
                sel_offset = OFFSET_WIDTH'(-m);
                sel_steps  = PHASE_WIDTH'(m);
            end
        end
        slip_request = found && (sync_count < threshold);
    end

    always_comb begin
        next_state = state;
        if (!reset) begin
            next_state = ST_SYNC;
        end else if (enable) begin
            case (state)
                ST_SYNC: begin
                    if (slip_request) begin
                        next_state = sel_offset[OFFSET_WIDTH-1] ? ST_RETARD : ST_ADVANCE;
                    end
                end
                ST_ADVANCE, ST_RETARD: begin
                    if (phase_left == PHASE_WIDTH'(1)) next_state = ST_RECOVER;
                end
                ST_RECOVER: begin
                    if (phase_left == PHASE_WIDTH'(1)) next_state = ST_CLEAR;
                end
                default: next_state = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_SYNC;
            phase_left  <= '0;
            extra_step  <= 1'b0;
            slip_event  <= 1'b0;
            slip_offset <= '0;
            slip_count  <= '0;
        end else begin
            state      <= next_state;
            slip_event <= 1'b0;
            // The extra LFSR step lands in the idle cycle right after the strobe
            extra_step <= enable && (next_state == ST_ADVANCE);
            if (enable) begin
                case (state)
                    ST_SYNC: begin
                        if (slip_request) begin
                            phase_left  <= sel_steps;
                            slip_event  <= 1'b1;
                            slip_offset <= sel_offset;
                            if (slip_count != {SLIP_COUNT_WIDTH{1'b1}}) begin
                                slip_count <= slip_count + 1'b1;
                            end
                        end
                    end
                    ST_ADVANCE, ST_RETARD: begin
                        if (phase_left == PHASE_WIDTH'(1)) begin
                            phase_left <= PHASE_WIDTH'(RECOVER_BITS);
                        end else begin
                            phase_left <= phase_left - 1'b1;
                        end
                    end
                    ST_RECOVER: phase_left <= phase_left - 1'b1;
                    default: phase_left <= '0;
                endcase
            end
        end
    end

    assign lfsr_enable = (enable && (next_state != ST_RETARD)) || extra_step;
    assign blackout    = enable && in_correction(next_state);

endmodule

// File: tb/tb_bert_slip_detect_n.sv
// tb/tb_bert_slip_detect_n.sv - randomized PN15 slip scenarios checked against a behavioural model
module tb_bert_slip_detect_n;
    import bert_pkg::*;

    localparam int SR = 2;
    localparam int CW = 8;
    localparam int RB = 4;
    localparam int NC = 2 * SR + 1;

    logic          clock;
    logic          reset;
    logic [CW-1:0] limit;
    logic [CW-1:0] threshold;
    logic          enable;
    logic          reload;
    logic          data;
    logic          code;
    logic          lfsr_enable;
    logic          blackout;
    logic          slip_event;
    logic [3:0]    slip_offset;
    logic [15:0]   slip_count;

    int checks = 0;
    int errors = 0;

    int          runs [NC];
    bit          dh[$];
    bit          ch[$];
    int          busy_pos, cur_k, mag, m_count;
    logic [3:0]  m_offset;
    int          lim_i, thr_i;
    logic [14:0] tx, rx;
    int          obs_events, obs_extra, obs_supp, obs_black;
    bit          exp_lfsr, exp_extra, exp_event, exp_black;
    int          exp_sync;

    bert_slip_detect_n #(
        .SLIP_RANGE   (SR),
        .CNT_WIDTH    (CW),
        .RECOVER_BITS (RB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .limit       (limit),
        .threshold   (threshold),
        .enable      (enable),
        .reload      (reload),
        .data        (data),
        .code        (code),
        .lfsr_enable (lfsr_enable),
        .blackout    (blackout),
        .slip_event  (slip_event),
        .slip_offset (slip_offset),
        .slip_count  (slip_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [14:0] pn_step(input logic [14:0] s);
        return {s[13:0], s[14] ^ s[13]};
    endfunction

    function automatic bit hd(input int idx);
        return (idx < 0) ? 1'b0 : dh[idx];
    endfunction

    function automatic bit hc(input int idx);
        return (idx < 0) ? 1'b0 : ch[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dh.delete();
        ch.delete();
        foreach (runs[i]) runs[i] = 0;
        busy_pos = -1;
        cur_k    = 0;
        mag      = 0;
        m_count  = 0;
        m_offset = 4'h0;
    endtask

    task automatic set_limits(input int lim, input int thr);
        lim_i     = lim;
        thr_i     = thr;
        limit     = CW'(lim);
        threshold = CW'(thr);
    endtask

    // One bit period: decision on stale run lengths, then correction schedule, then run update
    task automatic model_strobe(input bit d, input bit c, input bit rl);
        int  t;
        bit  decided;
        bit  clear_now;
        dh.push_back(d);
        ch.push_back(c);
        t         = dh.size() - 1;
        exp_sync  = runs[SR];
        exp_lfsr  = 1'b1;
        exp_extra = 1'b0;
        exp_event = 1'b0;
        exp_black = 1'b0;
        clear_now = 1'b0;
        decided   = 1'b0;
        if (busy_pos < 0 && runs[SR] < thr_i) begin
            for (int m = 1; m <= SR; m++) begin
                if (!decided && runs[SR + m] > thr_i) begin
                    cur_k = m; decided = 1'b1;
                end else if (!decided && runs[SR - m] > thr_i) begin
                    cur_k = -m; decided = 1'b1;
                end
            end
            if (decided) begin
                busy_pos  = 0;
                mag       = (cur_k < 0) ? -cur_k : cur_k;
                m_offset  = 4'(cur_k);
                if (m_count < 65535) m_count++;
                exp_event = 1'b1;
            end
        end
        if (busy_pos >= 0) begin
            exp_black = (busy_pos <= mag + RB);
            if (busy_pos < mag) begin
                exp_lfsr  = (cur_k > 0);
                exp_extra = (cur_k > 0);
            end
            clear_now = (busy_pos == mag + RB + 1);
            busy_pos  = clear_now ? -1 : busy_pos + 1;
        end
        for (int i = 0; i < NC; i++) begin
            if (rl || clear_now || (hd(t - SR) != hc(t - SR + (i - SR)))) runs[i] = 0;
            else if (runs[i] < lim_i) runs[i]++;
        end
    endtask

    task automatic send_bit(input bit d, input bit rl, input int gap);
        enable = 1'b1;
        data   = d;
        code   = rx[14];
        reload = rl;
        model_strobe(d, rx[14], rl);
        @(negedge clock);
        check("lfsr_on_strobe", lfsr_enable, exp_lfsr);
        check("blackout", blackout, exp_black);
        check("slip_event_on_strobe", slip_event, 1'b0);
        check("sync_run", dut.sync_count, exp_sync);
        obs_black += int'(blackout);
        obs_supp  += int'(!lfsr_enable);
        @(posedge clock); #1;
        enable = 1'b0;
        reload = 1'b0;
        for (int cyc = 1; cyc < gap; cyc++) begin
            @(negedge clock);
            check("lfsr_extra", lfsr_enable, (cyc == 1) && exp_extra);
            check("slip_event", slip_event, (cyc == 1) && exp_event);
            check("blackout_idle", blackout, 1'b0);
            check("slip_offset", slip_offset, m_offset);
            check("slip_count", slip_count, m_count);
            obs_extra  += int'(lfsr_enable);
            obs_events += int'(slip_event);
            @(posedge clock); #1;
        end
        if (exp_lfsr)  rx = pn_step(rx);
        if (exp_extra) rx = pn_step(rx);
    endtask

    task automatic send_pn(input int n, input int rl_period, input bit rl_in_corr);
        for (int b = 0; b < n; b++) begin
            bit d;
            bit rl;
            d  = tx[14];
            tx = pn_step(tx);
            rl = (rl_period > 0 && (b % rl_period) == rl_period - 1) ||
                 (rl_in_corr && busy_pos >= 0);
            send_bit(d, rl, int'($urandom_range(2, 4)));
        end
    endtask

    task automatic drop_bits(input int n);
        for (int i = 0; i < n; i++) tx = pn_step(tx);
    endtask

    task automatic insert_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(2, 4)));
    endtask

    task automatic clear_obs();
        obs_events = 0; obs_extra = 0; obs_supp = 0; obs_black = 0;
    endtask

    task automatic do_reset();
        logic [14:0] seed;
        reset  = 1'b0;
        enable = 1'b0;
        reload = 1'b0;
        data   = 1'b0;
        code   = 1'b0;
        @(posedge clock); #1;
        model_reset();
        seed  = 15'($urandom_range(1, 32767));
        tx    = seed;
        rx    = seed;
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        reload = 1'b0;
        data   = 1'b0;
        code   = 1'b0;
        set_limits(200, 100);
        #1 reset = 1'b0;
        #2;
        check("rst_slip_event", slip_event, 1'b0);
        check("rst_slip_offset", slip_offset, 4'h0);
        check("rst_slip_count", slip_count, 16'h0);
        check("rst_blackout", blackout, 1'b0);
        check("rst_lfsr_idle", lfsr_enable, 1'b0);
        enable = 1'b1;
        #1;
        check("rst_lfsr_follows_enable", lfsr_enable, 1'b1);
        check("rst_blackout_enable", blackout, 1'b0);
        do_reset();

        // Aligned PN15 stream
        clear_obs();
        send_pn(1000, 0, 1'b0);
        check("aligned_events", obs_events, 0);
        check("aligned_blackout", obs_black, 0);
        check("aligned_suppressed", obs_supp, 0);
        check("aligned_extra", obs_extra, 0);

        // One received bit lost, reload pulsed while correcting
        clear_obs();
        drop_bits(1);
        send_pn(250, 0, 1'b1);
        check("drop1_events", obs_events, 1);
        check("drop1_extra", obs_extra, 1);
        check("drop1_blackout", obs_black, 6);
        check("drop1_offset", slip_offset, 4'h1);
        check("drop1_count", slip_count, 16'd1);

        // Two spurious bits inserted
        clear_obs();
        insert_bits(2);
        send_pn(420, 0, 1'b0);
        check("ins2_events", obs_events, 1);
        check("ins2_suppressed", obs_supp, 2);
        check("ins2_offset", slip_offset, 4'hE);
        check("ins2_count", slip_count, 16'd2);
        check("ins2_relock_sync", dut.sync_count, 8'd200);

        // Slip larger than the correctable range
        clear_obs();
        drop_bits(3);
        send_pn(300, 0, 1'b0);
        check("slip3_events", obs_events, 0);
        check("slip3_sync_below", dut.sync_count < 8'd100, 1'b1);

        // Reset while the LFSR is being advanced
        do_reset();
        send_pn(60, 0, 1'b0);
        drop_bits(1);
        for (int b = 0; b < 400 && busy_pos < 0; b++) send_pn(1, 0, 1'b0);
        check("adv_reached", busy_pos >= 0, 1'b1);
        check("adv_count_before_reset", slip_count, 16'd1);
        reset = 1'b0;
        #1;
        check("adv_rst_state", dut.state, ST_SYNC);
        check("adv_rst_slip_event", slip_event, 1'b0);
        check("adv_rst_offset", slip_offset, 4'h0);
        check("adv_rst_count", slip_count, 16'h0);
        check("adv_rst_blackout", blackout, 1'b0);
        check("adv_rst_lfsr", lfsr_enable, 1'b0);
        enable = 1'b1;
        #1;
        check("adv_rst_lfsr_enable", lfsr_enable, 1'b1);
        check("adv_rst_blackout_enable", blackout, 1'b0);
        do_reset();

        // Periodic reload keeps every run short of threshold
        clear_obs();
        send_pn(150, 50, 1'b0);
        drop_bits(1);
        send_pn(300, 50, 1'b0);
        check("reload_events", obs_events, 0);

        // limit below threshold, then zero limit and threshold
        clear_obs();
        set_limits(50, 100);
        send_pn(200, 0, 1'b0);
        check("low_limit_events", obs_events, 0);
        set_limits(0, 0);
        send_pn(100, 0, 1'b0);
        check("zero_limit_events", obs_events, 0);
        set_limits(200, 100);
        send_pn(250, 0, 1'b0);
        check("restored_events", obs_events, 1);
        check("restored_offset", slip_offset, 4'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bert_slip_detect_n.md
BERT_SLIP_DETECT_N -- requirements
Module: bert_slip_detect_n

Interface
REQ-001 Parameter SLIP_RANGE, default 2: maximum correctable slip magnitude in bits, range 1..7.
REQ-002 Parameter CNT_WIDTH, default 8: width of run counters, limit and threshold, range 4..16.
REQ-003 Parameter RECOVER_BITS, default 4: bit periods allowed from last LFSR correction to valid data, range 1..15.
REQ-004 clock  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 limit  input  CNT_WIDTH  run-counter saturation value.
REQ-007 threshold  input  CNT_WIDTH  decision threshold.
REQ-008 enable  input  1  one-cycle bit strobe; all state advances only on enable.
REQ-009 reload  input  1  LFSR reload indication; clears all run counters when sampled with enable.
REQ-010 data  input  1  received bit, valid with enable.
REQ-011 code  input  1  local LFSR reference bit, valid with enable.
REQ-012 lfsr_enable  output  1  LFSR step strobe, combinational from enable and next state.
REQ-013 blackout  output  1  error-count suppression, combinational.
REQ-014 slip_event  output  1  registered one-cycle pulse when a correction is committed.
REQ-015 slip_offset  output  4  signed two's-complement offset of the last committed correction, held until next commit.
REQ-016 slip_count  output  16  committed corrections since reset, saturating at 16'hFFFF.

Function
REQ-017 Data shall be delayed SLIP_RANGE bits; code shall be held in a (2*SLIP_RANGE+1)-bit shift register, newest at top.
REQ-018 Candidate offset k (-SLIP_RANGE..+SLIP_RANGE) compares delayed data with the code tap SLIP_RANGE-k bits old; k=0 is sync, k>0 early, k<0 late.
REQ-019 Each candidate run counter shall, on enable: clear if clear_count or reload; else clear on mismatch; else increment while below limit (saturate at limit).
REQ-020 States: SYNC, ADVANCE, RETARD, RECOVER, CLEAR; state changes only on enable.
REQ-021 SYNC: if sync counter < threshold and some k≠0 counter > threshold, select the smallest |k|, positive k winning ties; k>0 -> ADVANCE, k<0 -> RETARD, load a remaining-steps counter with |k|; otherwise stay in SYNC.
REQ-022 ADVANCE: lfsr_enable asserted on enable and on the cycle after enable (extra step); decrement per bit; go to RECOVER after the |k|-th bit.
REQ-023 RETARD: lfsr_enable suppressed for |k| enable strobes, then RECOVER.
REQ-024 Outside ADVANCE/RETARD, lfsr_enable equals enable.
REQ-025 RECOVER: lasts RECOVER_BITS bit periods, then CLEAR; CLEAR lasts one bit period, asserts clear_count, then SYNC.
REQ-026 blackout = enable while next state is ADVANCE, RETARD, RECOVER or CLEAR.
REQ-027 On the SYNC->ADVANCE/RETARD transition: pulse slip_event, load slip_offset with k, increment slip_count.
REQ-028 limit < threshold shall never trigger a correction; threshold = 0 with limit = 0 shall keep SYNC.
REQ-029 reload during a correction shall clear counters but not abort the state sequence.

Reset
REQ-030 reset low shall asynchronously clear all shift registers, counters, slip_offset, slip_count and slip_event, and force state SYNC.
REQ-031 During reset lfsr_enable shall equal enable and blackout shall be 0; reset mid-correction discards remaining steps.

Structure
REQ-032 Shared package bert_pkg holds the state encoding and the SLIP_RANGE/offset width constants.
REQ-033 Sub-module bert_run_counter (clear, mismatch, limit, saturating count) instantiated 2*SLIP_RANGE+1 times.

Verification
REQ-034 Aligned PN15, limit=200, threshold=100, 1000 bits -> no slip_event, lfsr_enable==enable, blackout never high.
REQ-035 Drop one received bit after lock -> slip_event with slip_offset=+1, exactly one extra lfsr_enable, blackout for 1+4+1 bits, slip_count=1.
REQ-036 Insert two received bits -> slip_offset=-2, two suppressed strobes, re-lock, sync counter reaches limit.
REQ-037 Slip of 3 with SLIP_RANGE=2 -> no slip_event, sync counter stays below threshold.
REQ-038 reset asserted during ADVANCE -> all outputs cleared immediately, state SYNC, slip_count=0.
REQ-039 Noise-free data with reload pulsed every 50 bits, threshold=100 -> no correction.
